// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register used when decode back-pressures a fetched word.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        rel,
    input  logic        flush,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        full,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (rel) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, InstructionMem read port, skid buffer, branch squash.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_address,
    output logic        mem_hit,
    input  logic [31:0] mem_instr,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        fault
);

`ifdef FETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pending_pc;
    logic         pending;
    logic         fault_q;

    logic         skid_full;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;
    logic         skid_load;
    logic         skid_rel;

    logic         transfer;
    logic         issue;
    logic         misaligned;
    logic [31:0]  target;

    always_comb begin
        misaligned = (br_target[1:0] != 2'b00);
        target     = br_target;
        if (!ALIGN_CHK) target[1:0] = 2'b00;

        dec_valid = !br_valid && (state == RUN) && (skid_full || pending);
        dec_instr = '0;
        dec_pc    = '0;
        if (skid_full) begin
            dec_instr = skid_instr;
            dec_pc    = skid_pc;
        end else if (pending) begin
            dec_instr = mem_instr;
            dec_pc    = pending_pc;
        end

        transfer = dec_valid && dec_ready;
        // A skid entry leaving this cycle frees the slot, so the next fetch
        // can issue alongside it and a stall costs no extra bubble.
        issue = !rst && (state == RUN) && (!skid_full || transfer) && !br_valid
                && !(pending && !dec_ready);

        skid_load = pending && !skid_full && !transfer && !br_valid;
        skid_rel  = skid_full && transfer;

        mem_hit     = issue;
        mem_address = pc;
        fault       = fault_q;
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .rel       (skid_rel),
        .flush     (br_valid),
        .in_instr  (mem_instr),
        .in_pc     (pending_pc),
        .full      (skid_full),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
            fault_q    <= 1'b0;
        end else if (br_valid) begin
            pc      <= target;
            pending <= 1'b0;
            if (ALIGN_CHK && misaligned) begin
                fault_q <= 1'b1;
                state   <= HALT;
            end
        end else begin
            pending <= issue;
            if (issue) begin
                pending_pc <= pc;
                pc         <= pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural InstructionMem and stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_address;
    logic        mem_hit;
    logic [31:0] mem_instr;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_address (mem_address),
        .mem_hit     (mem_hit),
        .mem_instr   (mem_instr),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .fault       (fault)
    );

    // InstructionMem: one-cycle read latency, output cleared by reset
    always @(posedge clk or posedge rst) begin
        if (rst) mem_instr <= '0;
        else if (mem_hit) mem_instr <= mem[mem_address[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        dec_ready = rdy;
        br_valid  = br;
        br_target = tgt;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    // Asserts rst off-edge, checks outputs instantly, models the memory clear.
    task automatic do_reset(input bit reload);
        #2;
        rst       = 1'b1;
        dec_ready = 1'b1;
        br_valid  = 1'b0;
        br_target = '0;
        #1;
        chk("rst_mem_hit", {31'b0, mem_hit}, 32'd0);
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        if (reload) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            mem[0] = 32'h11;
            mem[1] = 32'h22;
            mem[2] = 32'h33;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          hits;
        int          since;
        logic [31:0] exp_pc;
        logic        r, b, exp_valid;
        logic [31:0] t;

        // Basic streaming after reset release
        do_reset(1);
        chk("c0_hit", {31'b0, mem_hit}, 32'd1);
        chk("c0_addr", mem_address, 32'h0);
        chk("c0_valid", {31'b0, dec_valid}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk("stream_hit", {31'b0, mem_hit}, 32'd1);
            chk("stream_addr", mem_address, 32'(i * 4));
            chk("stream_valid", {31'b0, dec_valid}, 32'd1);
            chk("stream_pc", dec_pc, 32'((i - 1) * 4));
            chk("stream_instr", dec_instr, 32'(i * 32'h11));
        end

        // Three-cycle stall while presenting pc 12
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, '0);
            chk("stall_valid", {31'b0, dec_valid}, 32'd1);
            chk("stall_pc", dec_pc, 32'd12);
            chk("stall_instr", dec_instr, rd(32'd12));
            if (mem_hit) hits++;
        end
        chk("stall_hits_le1", {31'b0, hits <= 1}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk("resume_valid", {31'b0, dec_valid}, 32'd1);
            chk("resume_pc", dec_pc, 32'(12 + i * 4));
            chk("resume_instr", dec_instr, rd(32'(12 + i * 4)));
        end

        // Redirect to 0x40 while the word at 0x8 is pending
        do_reset(1);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        chk("pre_br_pc", dec_pc, 32'h4);
        cyc(1'b1, 1'b1, 32'h40);
        chk("br_valid_low", {31'b0, dec_valid}, 32'd0);
        chk("br_hit_low", {31'b0, mem_hit}, 32'd0);
        cyc(1'b1, 1'b0, '0);
        chk("br_n1_hit", {31'b0, mem_hit}, 32'd1);
        chk("br_n1_addr", mem_address, 32'h40);
        chk("br_n1_valid", {31'b0, dec_valid}, 32'd0);
        cyc(1'b1, 1'b0, '0);
        chk("br_n2_valid", {31'b0, dec_valid}, 32'd1);
        chk("br_n2_pc", dec_pc, 32'h40);
        chk("br_n2_instr", dec_instr, rd(32'h40));

        // Redirect with skid full and decode ready: skid word must vanish
        cyc(1'b0, 1'b0, '0);
        chk("skid_fill_pc", dec_pc, 32'h44);
        cyc(1'b1, 1'b1, 32'h80);
        chk("skbr_valid", {31'b0, dec_valid}, 32'd0);
        chk("skbr_hit", {31'b0, mem_hit}, 32'd0);
        cyc(1'b1, 1'b0, '0);
        chk("skbr_n1_addr", mem_address, 32'h80);
        chk("skbr_n1_valid", {31'b0, dec_valid}, 32'd0);
        cyc(1'b1, 1'b0, '0);
        chk("skbr_n2_valid", {31'b0, dec_valid}, 32'd1);
        chk("skbr_n2_pc", dec_pc, 32'h80);

        // Misaligned redirect
        cyc(1'b1, 1'b1, 32'h42);
        chk("mis_valid", {31'b0, dec_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk("halt_fault", {31'b0, fault}, 32'd1);
            chk("halt_hit", {31'b0, mem_hit}, 32'd0);
            chk("halt_valid", {31'b0, dec_valid}, 32'd0);
        end
`else
        cyc(1'b1, 1'b0, '0);
        chk("mis_fault", {31'b0, fault}, 32'd0);
        chk("mis_addr", mem_address, 32'h40);
        chk("mis_hit", {31'b0, mem_hit}, 32'd1);
        cyc(1'b1, 1'b0, '0);
        chk("mis_pc", dec_pc, 32'h40);
        chk("mis_dvalid", {31'b0, dec_valid}, 32'd1);
`endif

        // Mid-stream async reset without reload: memory reads back zero
        cyc(1'b1, 1'b0, '0);
        do_reset(0);
        chk("rr_hit", {31'b0, mem_hit}, 32'd1);
        chk("rr_addr", mem_address, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk("rr_valid", {31'b0, dec_valid}, 32'd1);
            chk("rr_pc", dec_pc, 32'(i * 4));
            chk("rr_instr", dec_instr, 32'd0);
        end

        // Random phase: valid must appear two cycles after any redirect and
        // persist; accepted words follow the program order from each target.
        do_reset(1);
        exp_pc = 32'h0;
        since  = 2;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 9) == 0);
            t = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            cyc(r, b, t);
            exp_valid = !b && (since >= 2);
            chk("rnd_valid", {31'b0, dec_valid}, {31'b0, exp_valid});
            if (b) begin
                exp_pc = t;
                since  = 0;
            end else if (exp_valid && r) begin
                chk("rnd_pc", dec_pc, exp_pc);
                chk("rnd_instr", dec_instr, rd(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            since++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
